lfsr_engine: RTL and testbench

Run-time configurable LFSR. It supports both Galois and Fibonacci feedback, a loadable prescaler, single-step advance, lockup detection and automatic period measurement. It is the multi-mode successor to the fixed Galois LFSR, and feeds pattern generators and test outputs. All configuration is registered inside the block, so callers only pulse the load strobes.

---
 rtl/lfsr_engine.sv | 193 +++++++++++++++++++
 tb/tb_lfsr_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_engine.sv
// lfsr_engine -- run-time configurable LFSR with Galois/Fibonacci feedback,
// loadable prescaler, single-step advance, lockup flag and period measurement.
//
// Ports:
//   clk                      clock
//   rst_i                    asynchronous active-high reset
//   load_i / seed_i          load state and seed register; clears prescaler and period logic
//   taps_load_i/taps_i/mode_i load tap mask and feedback mode (0 Galois, 1 Fibonacci)
//   div_load_i / div_i       load prescaler divisor D (advance every D+1 clocks)
//   enable_i                 free-running advance enable
//   step_i                   force one advance this cycle
//   state_o                  current state
//   bit_o                    bit shifted out by the last advance
//   valid_o                  one-cycle pulse aligned with an updated state_o/bit_o
//   lockup_o                 state_o is all zeros
//   period_o                 measured period (advances from seed back to seed)
//   period_valid_o           period_o valid (sticky until load_i or reset)
//   period_ovf_o             step counter saturated before the seed recurred (sticky)
module lfsr_engine #(
   parameter int              BITS       = 16,
   parameter int              TICK_BITS  = 8,
   parameter logic [BITS-1:0] RESET_TAPS = BITS'(16'hB400),
   parameter logic [BITS-1:0] RESET_SEED = BITS'(1'b1)
) (
   input  logic                 clk,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic [BITS-1:0]      seed_i,
   input  logic                 taps_load_i,
   input  logic [BITS-1:0]      taps_i,
   input  logic                 mode_i,
   input  logic                 div_load_i,
   input  logic [TICK_BITS-1:0] div_i,
   input  logic                 enable_i,
   input  logic                 step_i,
   output logic [BITS-1:0]      state_o,
   output logic                 bit_o,
   output logic                 valid_o,
   output logic                 lockup_o,
   output logic [BITS-1:0]      period_o,
   output logic                 period_valid_o,
   output logic                 period_ovf_o
);

   localparam logic [BITS-1:0]      ZERO_C     = {BITS{1'b0}};
   localparam logic [BITS-1:0]      ONES_C     = {BITS{1'b1}};
   localparam logic [BITS-1:0]      ONE_C      = BITS'(1'b1);
   localparam logic [TICK_BITS-1:0] TICK_ZERO_C = {TICK_BITS{1'b0}};
   localparam logic [TICK_BITS-1:0] TICK_ONE_C  = TICK_BITS'(1'b1);

   // Galois: shift right, fold the tap mask in when a 1 falls out.
   function automatic logic [BITS-1:0] galois_next(input logic [BITS-1:0] s,
                                                   input logic [BITS-1:0] t);
      galois_next = (s >> 1'b1) ^ (s[0] ? t : ZERO_C);
   endfunction

   // Fibonacci: parity of the tapped bits enters at the MSB.
   function automatic logic [BITS-1:0] fib_next(input logic [BITS-1:0] s,
                                                input logic [BITS-1:0] t);
      fib_next = {^(s & t), s[BITS-1:1]};
   endfunction

   logic [BITS-1:0]      state_q,  state_d;
   logic [BITS-1:0]      seed_q,   seed_d;
   logic [BITS-1:0]      taps_q,   taps_d;
   logic                 mode_q,   mode_d;
   logic [TICK_BITS-1:0] div_q,    div_d;
   logic [TICK_BITS-1:0] tick_q,   tick_d;
   logic [BITS-1:0]      cnt_q,    cnt_d;
   logic                 bit_q,    bit_d;
   logic                 valid_q,  valid_d;
   logic [BITS-1:0]      period_q, period_d;
   logic                 pvalid_q, pvalid_d;
   logic                 povf_q,   povf_d;

   logic [BITS-1:0]      next_s;
   logic [BITS-1:0]      cnt_inc_s;
   logic                 wrap_s;
   logic                 advance_s;

   // Feedback selection, prescaler wrap and advance request.
   always_comb begin
      next_s    = mode_q ? fib_next(state_q, taps_q) : galois_next(state_q, taps_q);
      cnt_inc_s = cnt_q + ONE_C;
      wrap_s    = (tick_q == div_q);
      // step_i and a free-running wrap in the same cycle merge into one advance.
      advance_s = step_i | (enable_i & wrap_s);
   end

   // Next-state logic with load > configuration > advance priority.
   always_comb begin
      state_d  = state_q;
      seed_d   = seed_q;
      taps_d   = taps_q;
      mode_d   = mode_q;
      div_d    = div_q;
      tick_d   = tick_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      valid_d  = 1'b0;
      period_d = period_q;
      pvalid_d = pvalid_q;
      povf_d   = povf_q;
      if (load_i) begin
         state_d  = seed_i;
         seed_d   = seed_i;
         tick_d   = TICK_ZERO_C;
         cnt_d    = ZERO_C;
         pvalid_d = 1'b0;
         povf_d   = 1'b0;
      end else if (taps_load_i || div_load_i) begin
         if (taps_load_i) begin
            taps_d = taps_i;
            mode_d = mode_i;
         end else begin
            taps_d = taps_q;
         end
         if (div_load_i) begin
            div_d  = div_i;
            tick_d = TICK_ZERO_C;
         end else begin
            div_d  = div_q;
         end
      end else begin
         if (enable_i) begin
            tick_d = wrap_s ? TICK_ZERO_C : (tick_q + TICK_ONE_C);
         end else begin
            tick_d = tick_q;
         end
         if (advance_s) begin
            state_d = next_s;
            bit_d   = state_q[0];
            valid_d = 1'b1;
            if (!pvalid_q && !povf_q) begin
               cnt_d = cnt_inc_s;
               // Recurrence wins over saturation so a full 2^BITS-1 period is reported.
               if (next_s == seed_q) begin
                  period_d = cnt_inc_s;
                  pvalid_d = 1'b1;
               end else if (cnt_inc_s == ONES_C) begin
                  povf_d = 1'b1;
               end else begin
                  povf_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end else begin
            state_d = state_q;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= RESET_SEED;
         seed_q   <= RESET_SEED;
         taps_q   <= RESET_TAPS;
         mode_q   <= 1'b0;
         div_q    <= TICK_ZERO_C;
         tick_q   <= TICK_ZERO_C;
         cnt_q    <= ZERO_C;
         bit_q    <= 1'b0;
         valid_q  <= 1'b0;
         period_q <= ZERO_C;
         pvalid_q <= 1'b0;
         povf_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         seed_q   <= seed_d;
         taps_q   <= taps_d;
         mode_q   <= mode_d;
         div_q    <= div_d;
         tick_q   <= tick_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         valid_q  <= valid_d;
         period_q <= period_d;
         pvalid_q <= pvalid_d;
         povf_q   <= povf_d;
      end
   end

   assign state_o        = state_q;
   assign bit_o          = bit_q;
   assign valid_o        = valid_q;
   assign lockup_o       = (state_q == ZERO_C);
   assign period_o       = period_q;
   assign period_valid_o = pvalid_q;
   assign period_ovf_o   = povf_q;

endmodule

// File: tb/tb_lfsr_engine.sv
// Self-checking bench for lfsr_engine at BITS=4, TICK_BITS=4.
module tb_lfsr_engine;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       load_i = 1'b0;
   logic [3:0] seed_i = 4'h0;
   logic       taps_load_i = 1'b0;
   logic [3:0] taps_i = 4'h0;
   logic       mode_i = 1'b0;
   logic       div_load_i = 1'b0;
   logic [3:0] div_i = 4'h0;
   logic       enable_i = 1'b0;
   logic       step_i = 1'b0;
   logic [3:0] state_o;
   logic       bit_o;
   logic       valid_o;
   logic       lockup_o;
   logic [3:0] period_o;
   logic       period_valid_o;
   logic       period_ovf_o;

   lfsr_engine #(
      .BITS(4), .TICK_BITS(4), .RESET_TAPS(4'hC), .RESET_SEED(4'h1)
   ) dut (
      .clk(clk), .rst_i(rst_i), .load_i(load_i), .seed_i(seed_i),
      .taps_load_i(taps_load_i), .taps_i(taps_i), .mode_i(mode_i),
      .div_load_i(div_load_i), .div_i(div_i), .enable_i(enable_i), .step_i(step_i),
      .state_o(state_o), .bit_o(bit_o), .valid_o(valid_o), .lockup_o(lockup_o),
      .period_o(period_o), .period_valid_o(period_valid_o), .period_ovf_o(period_ovf_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state.
   logic [3:0] m_state, m_seed, m_taps, m_period;
   bit         m_mode, m_bit, m_valid, m_pv, m_po;
   int         m_div, m_tick, m_steps;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One LFSR step computed arithmetically: halving is the right shift.
   function automatic logic [3:0] m_next(input logic [3:0] s, input logic [3:0] t, input bit fib);
      int v, fb;
      v = int'(s);
      if (!fib) begin
         if (v % 2 == 1) return 4'(v / 2) ^ t;
         return 4'(v / 2);
      end
      fb = $countones(s & t) % 2;
      return 4'(fb * 8 + v / 2);
   endfunction

   task automatic m_reset();
      m_state = 4'h1; m_seed = 4'h1; m_taps = 4'hC; m_mode = 1'b0;
      m_div = 0; m_tick = 0; m_steps = 0; m_bit = 1'b0; m_valid = 1'b0;
      m_period = 4'h0; m_pv = 1'b0; m_po = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"},  16'(state_o),        16'(m_state));
      chk({tag, ".bit"},    16'(bit_o),          16'(m_bit));
      chk({tag, ".valid"},  16'(valid_o),        16'(m_valid));
      chk({tag, ".lockup"}, 16'(lockup_o),       16'(m_state == 4'h0));
      chk({tag, ".period"}, 16'(period_o),       16'(m_period));
      chk({tag, ".pvalid"}, 16'(period_valid_o), 16'(m_pv));
      chk({tag, ".povf"},   16'(period_ovf_o),   16'(m_po));
   endtask

   // Predict the effect of the current inputs, clock once, compare.
   task automatic cycle(input string tag);
      bit adv;
      m_valid = 1'b0;
      if (load_i) begin
         m_state = seed_i; m_seed = seed_i; m_tick = 0; m_steps = 0;
         m_pv = 1'b0; m_po = 1'b0;
      end else if (taps_load_i || div_load_i) begin
         if (taps_load_i) begin m_taps = taps_i; m_mode = mode_i; end
         if (div_load_i) begin m_div = int'(div_i); m_tick = 0; end
      end else begin
         adv = step_i || (enable_i && m_tick == m_div);
         if (enable_i) m_tick = (m_tick == m_div) ? 0 : m_tick + 1;
         if (adv) begin
            m_bit = m_state[0];
            m_state = m_next(m_state, m_taps, m_mode);
            m_valid = 1'b1;
            if (!m_pv && !m_po) begin
               m_steps++;
               if (m_state == m_seed) begin
                  m_pv = 1'b1; m_period = 4'(m_steps);
               end else if (m_steps == 15) begin
                  m_po = 1'b1;
               end
            end
         end
      end
      @(posedge clk); #1;
      check_all(tag);
   endtask

   logic [3:0] gal_seq [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                                4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
   logic [3:0] fib_seq [5]  = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC};
   logic       gal_bit [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   int         vcnt;

   initial begin
      m_reset();
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_i = 1'b0;

      // Galois taps C, seed 1, divisor 0.
      taps_load_i = 1'b1; taps_i = 4'hC; mode_i = 1'b0;
      cycle("gtaps");
      taps_load_i = 1'b0;
      load_i = 1'b1; seed_i = 4'h1;
      cycle("gload");
      load_i = 1'b0;
      enable_i = 1'b1;
      for (int i = 0; i < 15; i++) begin
         cycle("gal");
         chk("gal.seq", 16'(state_o), 16'(gal_seq[i]));
         chk("gal.valid", 16'(valid_o), 16'h1);
         if (i < 5) chk("gal.bit", 16'(bit_o), 16'(gal_bit[i]));
      end
      chk("gal.period", 16'(period_o), 16'd15);
      chk("gal.pvalid", 16'(period_valid_o), 16'h1);

      // Fibonacci taps 3, seed 1.
      enable_i = 1'b0;
      taps_load_i = 1'b1; taps_i = 4'h3; mode_i = 1'b1;
      cycle("ftaps");
      taps_load_i = 1'b0;
      load_i = 1'b1; seed_i = 4'h1;
      cycle("fload");
      load_i = 1'b0;
      chk("fload.pvalid", 16'(period_valid_o), 16'h0);
      enable_i = 1'b1;
      for (int i = 0; i < 15; i++) begin
         cycle("fib");
         if (i < 5) chk("fib.seq", 16'(state_o), 16'(fib_seq[i]));
      end
      chk("fib.period", 16'(period_o), 16'd15);
      chk("fib.pvalid", 16'(period_valid_o), 16'h1);

      // Divisor 3: one advance per 4 clocks; step_i mid-interval and on the wrap.
      enable_i = 1'b0;
      div_load_i = 1'b1; div_i = 4'd3;
      cycle("dload");
      div_load_i = 1'b0;
      enable_i = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 12; i++) begin
         cycle("div3");
         if (valid_o) vcnt++;
      end
      chk("div3.count", 16'(vcnt), 16'd3);
      vcnt = 0;
      for (int i = 0; i < 12; i++) begin
         step_i = (i == 1);
         cycle("div3.step");
         if (valid_o) vcnt++;
      end
      chk("div3.step.count", 16'(vcnt), 16'd4);
      vcnt = 0;
      for (int i = 0; i < 12; i++) begin
         step_i = (i == 3);
         cycle("div3.wrapstep");
         if (valid_o) vcnt++;
      end
      step_i = 1'b0;
      chk("div3.wrapstep.count", 16'(vcnt), 16'd3);
      enable_i = 1'b0;

      // Seed 0: lockup, period 1, state stays 0.
      load_i = 1'b1; seed_i = 4'h0;
      cycle("z.load");
      load_i = 1'b0;
      chk("z.lockup", 16'(lockup_o), 16'h1);
      step_i = 1'b1;
      cycle("z.step");
      step_i = 1'b0;
      chk("z.period", 16'(period_o), 16'h1);
      chk("z.pvalid", 16'(period_valid_o), 16'h1);
      chk("z.state", 16'(state_o), 16'h0);
      chk("z.valid", 16'(valid_o), 16'h1);
      // Configuration load blocks a coincident advance.
      step_i = 1'b1; taps_load_i = 1'b1; taps_i = 4'hC; mode_i = 1'b0;
      cycle("z.tapsblock");
      step_i = 1'b0; taps_load_i = 1'b0;
      chk("z.tapsblock.valid", 16'(valid_o), 16'h0);

      // Non-recurring sequence: overflow after exactly 15 advances.
      taps_load_i = 1'b1; taps_i = 4'h8; mode_i = 1'b1;
      cycle("o.taps");
      taps_load_i = 1'b0;
      load_i = 1'b1; seed_i = 4'h3;
      cycle("o.load");
      load_i = 1'b0;
      step_i = 1'b1;
      for (int i = 0; i < 14; i++) cycle("o.step");
      chk("o.povf14", 16'(period_ovf_o), 16'h0);
      cycle("o.step15");
      step_i = 1'b0;
      chk("o.povf15", 16'(period_ovf_o), 16'h1);
      chk("o.pvalid", 16'(period_valid_o), 16'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         load_i      = ($urandom_range(0, 19) == 0);
         seed_i      = 4'($urandom_range(0, 15));
         taps_load_i = ($urandom_range(0, 19) == 0);
         taps_i      = 4'($urandom_range(0, 15));
         mode_i      = 1'($urandom_range(0, 1));
         div_load_i  = ($urandom_range(0, 24) == 0);
         div_i       = 4'($urandom_range(0, 3));
         enable_i    = ($urandom_range(0, 3) != 0);
         step_i      = ($urandom_range(0, 7) == 0);
         cycle("rand");
      end
      load_i = 1'b0; taps_load_i = 1'b0; div_load_i = 1'b0; step_i = 1'b0;

      // Asynchronous reset in the middle of a cycle.
      enable_i = 1'b1;
      load_i = 1'b1; seed_i = 4'h6;
      cycle("r.load");
      load_i = 1'b0;
      cycle("r.run");
      #2;
      rst_i = 1'b1;
      #1;
      m_reset();
      chk("r.async.state", 16'(state_o), 16'h1);
      chk("r.async.valid", 16'(valid_o), 16'h0);
      chk("r.async.pvalid", 16'(period_valid_o), 16'h0);
      chk("r.async.povf", 16'(period_ovf_o), 16'h0);
      @(posedge clk); #1;
      check_all("r.hold");
      rst_i = 1'b0;
      chk("r.release.valid", 16'(valid_o), 16'h0);
      cycle("r.after");
      cycle("r.after2");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
